// File: rtl/lfsr_gen_pkg.sv
// Shared constants and the single-step Galois LFSR function used by the step chain.
// Steps are computed on a 64-bit carrier so one function serves every state width.
package lfsr_gen_pkg;

  localparam int          LFSR_MAX_W    = 64;
  localparam logic [15:0] LFSR_DEF_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_DEF_INIT = 16'hACE1;

  // Returns {next_state, out_bit}; unused upper state bits must be zero on entry.
  function automatic logic [LFSR_MAX_W:0] lfsr_step(
    input logic [LFSR_MAX_W-1:0] state,
    input logic [LFSR_MAX_W-1:0] taps
  );
    logic [LFSR_MAX_W-1:0] nxt;
    nxt = state >> 1;
    if (state[0]) begin
      nxt = nxt ^ taps;
    end
    return {nxt, state[0]};
  endfunction

endpackage

// File: rtl/lfsr_step_chain.sv
// Combinational chain of g_recurse Galois steps; returns final state and shifted-out bits.
// With LFSR_GEN_WRAP_DET_EN defined it also flags every step that lands on g_init_value.
module lfsr_step_chain
  import lfsr_gen_pkg::*;
#(
  parameter int                  g_length     = 16,
  parameter logic [g_length-1:0] g_taps       = LFSR_DEF_TAPS,
  parameter int                  g_recurse    = 1,
  parameter logic [g_length-1:0] g_init_value = LFSR_DEF_INIT
) (
  input  logic [g_length-1:0]  state_in,
  output logic [g_length-1:0]  state_out,
`ifdef LFSR_GEN_WRAP_DET_EN
  output logic [g_recurse-1:0] match_out,
`endif
  output logic [g_recurse-1:0] bits_out
);

  logic [g_length-1:0] stage [0:g_recurse];

  assign stage[0]  = state_in;
  assign state_out = stage[g_recurse];

  generate
    for (genvar gi = 0; gi < g_recurse; gi++) begin : g_step
      logic [LFSR_MAX_W:0] step_res;

      assign step_res      = lfsr_step(LFSR_MAX_W'(stage[gi]), LFSR_MAX_W'(g_taps));
      assign stage[gi + 1] = step_res[g_length:1];
      assign bits_out[gi]  = step_res[0];

      // Carrier bits above the state width are always zero after a step.
      if (g_length < LFSR_MAX_W) begin : g_pad
        logic unused_hi;
        assign unused_hi = ^step_res[LFSR_MAX_W:g_length+1];
      end

`ifdef LFSR_GEN_WRAP_DET_EN
      assign match_out[gi] = (stage[gi + 1] == g_init_value);
`endif
    end
  endgenerate

  // Keeps the parameter referenced in builds without wrap detection.
  logic [g_length-1:0] unused_init;
  assign unused_init = g_init_value;

endmodule

// File: rtl/lfsr_generator.sv
// Galois LFSR generator advancing g_recurse steps per enabled clock, with seed load.
// Optional wrap_o output (pulse when the sequence returns to g_init_value) via LFSR_GEN_WRAP_DET_EN.
module lfsr_generator
  import lfsr_gen_pkg::*;
#(
  parameter int                  g_length     = 16,
  parameter logic [g_length-1:0] g_taps       = LFSR_DEF_TAPS,
  parameter int                  g_recurse    = 1,
  parameter logic [g_length-1:0] g_init_value = LFSR_DEF_INIT
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic                 load_i,
  input  logic [g_length-1:0]  seed_i,
  output logic [g_length-1:0]  value_o,
  output logic [g_recurse-1:0] bits_o,
`ifdef LFSR_GEN_WRAP_DET_EN
  output logic                 wrap_o,
`endif
  output logic                 valid_o
);

  logic [g_length-1:0]  state_reg;
  logic [g_recurse-1:0] bits_reg;
  logic                 valid_reg;
  logic [g_length-1:0]  state_next;
  logic [g_recurse-1:0] bits_next;
  logic [g_length-1:0]  load_value;

  // A zero seed would lock the register at zero, so substitute the reset seed.
  assign load_value = (seed_i == '0) ? g_init_value : seed_i;

`ifdef LFSR_GEN_WRAP_DET_EN
  logic [g_recurse-1:0] match_next;
  logic                 wrap_reg;
`endif

  lfsr_step_chain #(
    .g_length     (g_length),
    .g_taps       (g_taps),
    .g_recurse    (g_recurse),
    .g_init_value (g_init_value)
  ) u_chain (
    .state_in  (state_reg),
    .state_out (state_next),
`ifdef LFSR_GEN_WRAP_DET_EN
    .match_out (match_next),
`endif
    .bits_out  (bits_next)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= g_init_value;
      bits_reg  <= '0;
      valid_reg <= 1'b0;
    end else if (load_i) begin
      state_reg <= load_value;
      valid_reg <= 1'b0;
    end else if (enable_i) begin
      state_reg <= state_next;
      bits_reg  <= bits_next;
      valid_reg <= 1'b1;
    end else begin
      valid_reg <= 1'b0;
    end
  end

`ifdef LFSR_GEN_WRAP_DET_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wrap_reg <= 1'b0;
    end else begin
      wrap_reg <= !load_i && enable_i && (|match_next);
    end
  end

  assign wrap_o = wrap_reg;
`endif

  assign value_o = state_reg;
  assign bits_o  = bits_reg;
  assign valid_o = valid_reg;

endmodule

// File: tb/tb_lfsr_generator.sv
// Self-checking bench: recurse-1 and recurse-4 generators against a step-by-step reference model.
// Wrap detection is exercised when LFSR_GEN_WRAP_DET_EN is defined.
module tb_lfsr_generator;

  localparam logic [15:0] TAPS = 16'hB400;
  localparam logic [15:0] INIT = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en1 = 1'b0;
  logic        en4 = 1'b0;
  logic        load = 1'b0;
  logic [15:0] seed = 16'h0;
  logic [15:0] val1, val4;
  logic [0:0]  bits1;
  logic [3:0]  bits4;
  logic        vld1, vld4;
`ifdef LFSR_GEN_WRAP_DET_EN
  logic        wrap1, wrap4;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model: index 0 is the recurse-1 instance, index 1 the recurse-4 instance.
  logic [15:0] m_state [2];
  logic [3:0]  m_bits  [2];
  logic        m_valid [2];
  int          m_rec   [2] = '{1, 4};

  always #5 clk = ~clk;

  lfsr_generator #(.g_recurse(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .enable_i(en1), .load_i(load), .seed_i(seed),
    .value_o(val1), .bits_o(bits1),
`ifdef LFSR_GEN_WRAP_DET_EN
    .wrap_o(wrap1),
`endif
    .valid_o(vld1)
  );

  lfsr_generator #(.g_recurse(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .enable_i(en4), .load_i(load), .seed_i(seed),
    .value_o(val4), .bits_o(bits4),
`ifdef LFSR_GEN_WRAP_DET_EN
    .wrap_o(wrap4),
`endif
    .valid_o(vld4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : 16'h0000);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_state[i] = INIT;
      m_bits[i]  = 4'h0;
      m_valid[i] = 1'b0;
    end
  endtask

  task automatic model_clock(input int i, input logic en);
    if (load) begin
      m_state[i] = (seed == 16'h0) ? INIT : seed;
      m_valid[i] = 1'b0;
    end else if (en) begin
      for (int k = 0; k < m_rec[i]; k++) begin
        m_bits[i][k] = m_state[i][0];
        m_state[i]   = ref_step(m_state[i]);
      end
      m_valid[i] = 1'b1;
    end else begin
      m_valid[i] = 1'b0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_clock(0, en1);
    model_clock(1, en4);
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_val1"}, 64'(val1), 64'(m_state[0]));
    check({tag, "_bits1"}, 64'(bits1), 64'(m_bits[0][0]));
    check({tag, "_vld1"}, 64'(vld1), 64'(m_valid[0]));
    check({tag, "_val4"}, 64'(val4), 64'(m_state[1]));
    check({tag, "_bits4"}, 64'(bits4), 64'(m_bits[1]));
    check({tag, "_vld4"}, 64'(vld4), 64'(m_valid[1]));
  endtask

  logic [15:0] seq1 [0:8] = '{16'hACE1, 16'hE270, 16'h7138, 16'h389C, 16'h1C4E,
                              16'h0E27, 16'hB313, 16'hED89, 16'hC2C4};

  initial begin
    model_reset();
    #50;
    compare_all("reset");
    #50;
    rst = 1'b0;

    // Known sequences: recurse-1 continuous, recurse-4 every 4th cycle.
    for (int c = 0; c < 8; c++) begin
      en1 = 1'b1;
      en4 = (c % 4 == 0);
      cycle();
      check($sformatf("seq1_%0d", c), 64'(val1), 64'(seq1[c + 1]));
      compare_all("seq");
      if (c == 0) begin
        check("seq4_first", 64'(val4), 64'h1C4E);
        check("seq4_bits", 64'(bits4), 64'h1);
      end
      if (c == 3) check("seq4_hold", 64'(val4), 64'h1C4E);
      if (c == 4) check("seq4_second", 64'(val4), 64'hC2C4);
    end

    // Load has priority over enable; zero seed substitutes the init value.
    en1 = 1'b1; en4 = 1'b1; load = 1'b1; seed = 16'h1234;
    cycle();
    check("load_val1", 64'(val1), 64'h1234);
    check("load_vld1", 64'(vld1), 64'h0);
    compare_all("load");
    seed = 16'h0000;
    cycle();
    check("load0_val1", 64'(val1), 64'hACE1);
    compare_all("load0");
    load = 1'b0;

    // Randomised enables, loads and seeds.
    for (int c = 0; c < 300; c++) begin
      en1  = 1'($urandom_range(0, 1));
      en4  = 1'($urandom_range(0, 1));
      load = ($urandom_range(0, 15) == 0);
      seed = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      cycle();
      compare_all("rand");
    end

    // Asynchronous reset between edges, then resume advancing.
    en1 = 1'b1; en4 = 1'b1; load = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all("arst");
    @(negedge clk);
    rst = 1'b0;
    cycle();
    compare_all("arst_resume");
    check("arst_resume_val1", 64'(val1), 64'hE270);

    // Recurse-4 after N enables matches recurse-1 after 4N enables.
    load = 1'b1; seed = 16'($urandom_range(1, 65535));
    cycle();
    load = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      en1 = 1'b1;
      en4 = (c % 4 == 0);
      cycle();
      if (c % 4 == 3) begin
        check("equiv_val4", 64'(val4), 64'(m_state[0]));
        check("equiv_val1", 64'(val1), 64'(m_state[0]));
      end
    end

`ifdef LFSR_GEN_WRAP_DET_EN
    begin
      int n;
      en1 = 1'b0; en4 = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      en1 = 1'b1;
      n = 0;
      while (n < 70000) begin
        @(posedge clk);
        #1;
        n++;
        if (wrap1) break;
      end
      check("wrap_first", 64'(n), 64'd65535);
      en1 = 1'b0;
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
